// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32 M-extension multiply/divide sequencer.
package mdu_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   localparam logic [CNT_W-1:0] CNT_LAST     = 5'd31;
   localparam logic [XLEN-1:0]  ALL_ONES     = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]  OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } mdu_state_e;

   function automatic logic op_is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic op_signed_a(input logic [2:0] op);
      return !((op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU));
   endfunction

   function automatic logic op_signed_b(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/mdu_sequencer_iter.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract-shift for divide.
module mdu_iter_step #(
   parameter int XLEN = 32
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] opb_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      acc_o   = acc_i;
      lo_o    = lo_i;
      sum     = '0;
      shifted = '0;
      diff    = '0;
      if (is_div) begin
         // acc holds the partial remainder, lo shifts the dividend out and quotient bits in
         shifted = {acc_i, lo_i[XLEN-1]};
         diff    = shifted - {1'b0, opb_i};
         if (!diff[XLEN]) begin
            acc_o = diff[XLEN-1:0];
            lo_o  = {lo_i[XLEN-2:0], 1'b1};
         end else begin
            acc_o = shifted[XLEN-1:0];
            lo_o  = {lo_i[XLEN-2:0], 1'b0};
         end
      end else begin
         // {acc, lo} shifts right; lo starts as the multiplier and ends as the low product
         sum   = {1'b0, acc_i} + ({(XLEN+1){lo_i[0]}} & {1'b0, opb_i});
         acc_o = sum[XLEN:1];
         lo_o  = {sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32 M-extension sequencer: 32-step multiply/divide with sign fix-up and special cases.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | ready for START; operands captured on acceptance
//  CALC  | 32 iterations, counter 0..31
//  FIN   | RESULT valid, DONE high for this one cycle
module mdu_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            START,
   input  logic [2:0]      OP,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   input  logic            FLUSH,
   output logic            READY,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT
);

   import mdu_pkg::*;

   mdu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   mdu_op_e           op_q, op_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              done_q, done_d;

   logic              accept;
   logic              neg1, neg2;
   logic [XLEN-1:0]   mag1, mag2;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   bypass_val;
   logic [XLEN-1:0]   step_acc, step_lo;
   logic [2*XLEN-1:0] prod_mag, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix;
   logic [XLEN-1:0]   fin_val;

   assign READY  = (state_q == IDLE);
   assign BUSY   = (state_q != IDLE) || (START && READY);
   assign DONE   = done_q;
   assign RESULT = result_q;
   assign accept = START && READY && !FLUSH;

   mdu_iter_step #(.XLEN(XLEN)) u_step (
      .is_div (op_is_div(op_q)),
      .acc_i  (acc_q),
      .lo_i   (lo_q),
      .opb_i  (opb_q),
      .acc_o  (step_acc),
      .lo_o   (step_lo)
   );

   always_comb begin
      neg1     = op_signed_a(OP) && DATA1[XLEN-1];
      neg2     = op_signed_b(OP) && DATA2[XLEN-1];
      mag1     = neg1 ? -DATA1 : DATA1;
      mag2     = neg2 ? -DATA2 : DATA2;
      div_zero = op_is_div(OP) && (DATA2 == '0);
      div_ovf  = ((OP == OP_DIV) || (OP == OP_REM)) &&
                 (DATA1 == OVF_DIVIDEND) && (DATA2 == ALL_ONES);
      if (div_zero) begin
         bypass_val = OP[1] ? DATA1 : ALL_ONES;
      end else begin
         bypass_val = OP[1] ? '0 : OVF_DIVIDEND;
      end
   end

   // Final iteration feeds the sign fix-up directly so RESULT loads on the edge into FIN.
   always_comb begin
      prod_mag = {step_acc, step_lo};
      prod_fix = neg_q ? -prod_mag : prod_mag;
      quo_fix  = neg_q ? -step_lo  : step_lo;
      rem_fix  = neg_q ? -step_acc : step_acc;
      case (op_q)
         OP_MUL:                       fin_val = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_val = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fin_val = quo_fix;
         default:                      fin_val = rem_fix;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      neg_d    = neg_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d  = mdu_op_e'(OP);
               neg_d = ((OP == OP_REM) || (OP == OP_REMU)) ? neg1 : (neg1 ^ neg2);
               if (div_zero || div_ovf) begin
                  state_d  = FIN;
                  result_d = bypass_val;
                  done_d   = 1'b1;
               end else begin
                  state_d = CALC;
                  cnt_d   = '0;
                  acc_d   = '0;
                  lo_d    = mag1;
                  opb_d   = mag2;
               end
            end
         end
         CALC: begin
            acc_d = step_acc;
            lo_d  = step_lo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d  = FIN;
               result_d = fin_val;
               done_d   = 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (FLUSH) begin
         state_d  = IDLE;
         result_d = result_q;
         done_d   = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= OP_MUL;
         acc_q    <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer with hand-computed results and latencies.
module tb_mdu_sequencer;

   logic        CLK;
   logic        RESET_N;
   logic        START;
   logic [2:0]  OP;
   logic [31:0] DATA1;
   logic [31:0] DATA2;
   logic        FLUSH;
   logic        READY;
   logic        BUSY;
   logic        DONE;
   logic [31:0] RESULT;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
   localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   mdu_sequencer #(.XLEN(32)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .START   (START),
      .OP      (OP),
      .DATA1   (DATA1),
      .DATA2   (DATA2),
      .FLUSH   (FLUSH),
      .READY   (READY),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .RESULT  (RESULT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Issues one op at the next negedge; lat counts negedges after the accepting edge until DONE.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      int busy_err;
      @(negedge CLK);
      n_total++;
      if (READY !== 1'b1 || DONE !== 1'b0) $display("FAIL %s idle: READY=%b DONE=%b want 1 0", name, READY, DONE);
      else n_pass++;
      OP = op; DATA1 = a; DATA2 = b; START = 1'b1;
      #1;
      n_total++;
      if (BUSY !== 1'b1) $display("FAIL %s busy_on_start: got %b want 1", name, BUSY);
      else n_pass++;
      @(posedge CLK);
      #1;
      START = 1'b0; OP = ~op; DATA1 = $urandom; DATA2 = $urandom;
      lat = 0;
      busy_err = 0;
      while (lat < 100) begin
         @(negedge CLK);
         lat++;
         if (BUSY !== 1'b1) busy_err++;
         if (DONE === 1'b1) break;
      end
      n_total++;
      if (lat != exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      else n_pass++;
      n_total++;
      if (RESULT !== exp_res) $display("FAIL %s result: got %h want %h", name, RESULT, exp_res);
      else n_pass++;
      n_total++;
      if (busy_err != 0) $display("FAIL %s busy_hold: %0d cycles low, want 0", name, busy_err);
      else n_pass++;
   endtask

   task automatic test_reset;
      RESET_N = 1'b0; START = 1'b0; FLUSH = 1'b0; OP = 3'b000; DATA1 = '0; DATA2 = '0;
      repeat (2) @(negedge CLK);
      n_total++;
      if (READY !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'h0)
         $display("FAIL reset_state: READY=%b BUSY=%b DONE=%b RESULT=%h want 1 0 0 0", READY, BUSY, DONE, RESULT);
      else n_pass++;
      START = 1'b1; DATA2 = 32'd0; OP = DIVU;
      #1;
      n_total++;
      if (BUSY !== 1'b1) $display("FAIL reset_busy_start: got %b want 1", BUSY);
      else n_pass++;
      @(negedge CLK);
      n_total++;
      if (READY !== 1'b1 || DONE !== 1'b0) $display("FAIL reset_dominates_start: READY=%b DONE=%b want 1 0", READY, DONE);
      else n_pass++;
      START = 1'b0;
      RESET_N = 1'b1;
   endtask

   task automatic test_mul;
      run_op("mul_7_m3",     MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      run_op("mulh_min_min", MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("mulhsu_m1",    MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      run_op("mulhu_max",    MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_op("mulhu_zero",   MULHU,  32'd0,        32'd5,        32'd0,        33);
      run_op("mul_shift",    MUL,    32'h00012345, 32'h00000100, 32'h01234500, 33);
   endtask

   task automatic test_div;
      run_op("div_m7_2",   DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem_m7_2",   REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("divu_100_7", DIVU, 32'd100,      32'd7,        32'd14,       33);
      run_op("remu_100_7", REMU, 32'd100,      32'd7,        32'd2,        33);
      run_op("div_7_m2",   DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
      run_op("rem_7_m2",   REM,  32'd7,        32'hFFFFFFFE, 32'd1,        33);
   endtask

   task automatic test_div_special;
      run_op("divu_by_zero", DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("rem_by_zero",  REM,  32'd5,        32'd0,        32'd5,        1);
      run_op("div_by_zero",  DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("div_overflow", DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("rem_overflow", REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
      run_op("remu_no_ovf",  REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
   endtask

   task automatic test_back_to_back;
      run_op("b2b_mul",  MUL,  32'd3,   32'd5, 32'd15,       33);
      run_op("b2b_divz", DIVU, 32'd9,   32'd0, 32'hFFFFFFFF, 1);
      run_op("b2b_remu", REMU, 32'd100, 32'd7, 32'd2,        33);
   endtask

   task automatic test_flush;
      int dones;
      run_op("flush_prep", DIVU, 32'd100, 32'd7, 32'd14, 33);
      @(negedge CLK);
      OP = MUL; DATA1 = 32'd7; DATA2 = 32'd3; START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         @(negedge CLK);
         if (i == 5) begin
            n_total++;
            if (READY !== 1'b0) $display("FAIL flush_calc_ready: got %b want 0", READY);
            else n_pass++;
            OP = DIVU; DATA1 = 32'd1; DATA2 = 32'd0; START = 1'b1;
         end else begin
            START = 1'b0;
         end
         if (i == 11) FLUSH = 1'b1;
      end
      @(negedge CLK);
      FLUSH = 1'b0;
      n_total++;
      if (READY !== 1'b1 || DONE !== 1'b0 || RESULT !== 32'd14)
         $display("FAIL flush_calc: READY=%b DONE=%b RESULT=%h want 1 0 0000000e", READY, DONE, RESULT);
      else n_pass++;
      dones = 0;
      repeat (40) begin
         @(negedge CLK);
         if (DONE === 1'b1) dones++;
      end
      n_total++;
      if (dones != 0) $display("FAIL flush_no_done: got %0d pulses want 0", dones);
      else n_pass++;
      OP = DIVU; DATA1 = 32'd1; DATA2 = 32'd0; START = 1'b1; FLUSH = 1'b1;
      @(negedge CLK);
      START = 1'b0; FLUSH = 1'b0;
      n_total++;
      if (READY !== 1'b1 || DONE !== 1'b0) $display("FAIL flush_start_idle: READY=%b DONE=%b want 1 0", READY, DONE);
      else n_pass++;
      dones = 0;
      repeat (5) begin
         @(negedge CLK);
         if (DONE === 1'b1) dones++;
      end
      n_total++;
      if (dones != 0 || RESULT !== 32'd14) $display("FAIL flush_start_ignored: dones=%0d RESULT=%h want 0 0000000e", dones, RESULT);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      int dones;
      @(negedge CLK);
      OP = MUL; DATA1 = 32'd6; DATA2 = 32'd6; START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      repeat (10) @(negedge CLK);
      RESET_N = 1'b0;
      @(negedge CLK);
      RESET_N = 1'b1;
      n_total++;
      if (READY !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'd0)
         $display("FAIL reset_mid: READY=%b BUSY=%b DONE=%b RESULT=%h want 1 0 0 0", READY, BUSY, DONE, RESULT);
      else n_pass++;
      dones = 0;
      repeat (40) begin
         @(negedge CLK);
         if (DONE === 1'b1) dones++;
      end
      n_total++;
      if (dones != 0) $display("FAIL reset_mid_no_done: got %0d pulses want 0", dones);
      else n_pass++;
      run_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 33);
   endtask

   initial begin
      test_reset;
      test_mul;
      test_div;
      test_div_special;
      test_back_to_back;
      test_flush;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; clock port CLK, reset port RESET_N.
REQ-002 The block SHALL have parameter XLEN, default 32: operand and result width in bits.
REQ-003 The block SHALL have these ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  synchronous active-low reset.
- START  in  1  request a new M-extension operation.
- OP  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DATA1  in  XLEN  rs1 operand.
- DATA2  in  XLEN  rs2 operand.
- FLUSH  in  1  abort the operation in flight.
- READY  out  1  high when the block can accept START.
- BUSY  out  1  pipeline stall request.
- DONE  out  1  one-cycle result-valid pulse.
- RESULT  out  XLEN  operation result.

Function
REQ-004 The block SHALL implement the states IDLE, CALC and FIN.
REQ-005 READY SHALL equal (state==IDLE); BUSY SHALL equal (state!=IDLE) OR (START AND READY).
REQ-006 Acceptance: START AND READY at edge T0 SHALL capture OP, DATA1 and DATA2; input changes after T0 SHALL be ignored.
REQ-007 START while READY is low SHALL be ignored, with no queuing.
REQ-008 Normal path: IDLE SHALL go to CALC at T0; CALC SHALL run exactly 32 cycles under a 5-bit counter running 0..31; CALC SHALL go to FIN at T0+32; DONE SHALL be high during the cycle after edge T0+32.
REQ-009 FIN SHALL last exactly one cycle and then return to IDLE; back-to-back issue SHALL be possible with START at the FIN→IDLE edge +1 cycle.
REQ-010 Multiply SHALL be radix-2 shift-add on operand magnitudes, giving a 64-bit product, with the sign fixed in FIN: MUL returns product[31:0]; MULH (s×s), MULHSU (s×u) and MULHU (u×u) return product[63:32].
REQ-011 Divide SHALL be radix-2 restoring division on magnitudes. The quotient sign is sign(DATA1) XOR sign(DATA2). The remainder sign follows DATA1. Rounding is truncation toward zero.
REQ-012 Divide by zero SHALL bypass CALC (IDLE→FIN at T0, DONE in the cycle after T0): DIV and DIVU return 0xFFFFFFFF; REM and REMU return DATA1.
REQ-013 Signed overflow (DIV/REM with DATA1=0x80000000, DATA2=0xFFFFFFFF) SHALL take the same bypass: DIV returns 0x80000000; REM returns 0.
REQ-014 RESULT SHALL be registered, update only on entry to FIN, and hold its value until the next FIN.
REQ-015 FLUSH in any state SHALL force IDLE at the next edge with no DONE pulse and RESULT unchanged; FLUSH together with START SHALL not accept the request.
REQ-016 Multiply by zero SHALL NOT take the bypass; it uses the normal 32-cycle latency.

Reset
REQ-017 RESET_N low at an edge SHALL force state=IDLE, counter=0, RESULT=0 and DONE=0, giving READY=1 and BUSY=0 (unless START is also high).
REQ-018 Reset SHALL dominate FLUSH and START; reset during CALC or FIN SHALL discard the operation with no DONE pulse.

Structure
REQ-019 Shared package mdu_pkg SHALL hold the OP encodings, the state enum (IDLE/CALC/FIN), XLEN and the overflow/all-ones constants.
REQ-020 The per-cycle add/shift and subtract/shift step SHALL be a sub-module mdu_iter_step (combinational, one iteration); sequencing, sign handling and special cases SHALL stay in mdu_sequencer.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- MUL: DATA1=7, DATA2=-3 -> DONE in cycle after T0+32, RESULT=0xFFFFFFEB; BUSY high T0..FIN.
- MULH: DATA1=0x80000000, DATA2=0x80000000 -> RESULT=0x40000000. MULHSU: DATA1=-1, DATA2=0xFFFFFFFF -> RESULT=0xFFFFFFFF. MULHU with the same operands -> RESULT=0xFFFFFFFE.
- DIV: DATA1=-7, DATA2=2 -> RESULT=0xFFFFFFFD. REM with the same operands -> RESULT=0xFFFFFFFF. DIVU: DATA1=100, DATA2=7 -> RESULT=14.
- Divide by zero: DIVU with DATA1=5, DATA2=0 -> DONE in cycle after T0, RESULT=0xFFFFFFFF. REM with DATA1=5, DATA2=0 -> RESULT=5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, with 1-cycle latency.
- FLUSH at CALC count 10 -> IDLE next edge, no DONE, RESULT retains prior value; a START pulsed during CALC is ignored.
- RESET_N low during CALC -> next cycle READY=1, RESULT=0, no DONE; a new DIVU 9/3 then completes with RESULT=3.
